albacore_memsys: RTL
====================

ALBACORE_MEMSYS -- requirements
Module: albacore_memsys

Interface
REQ-001 The block SHALL have ports: clk  input  1  rising-edge system clock.
REQ-002 The block SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 The block SHALL have ports: addr  input  16  word address driven by the CPU.
REQ-004 The block SHALL have ports: wdata  input  16  CPU write data (the CPU's dout).
REQ-005 The block SHALL have ports: we  input  1  CPU write enable, active high.
REQ-006 The block SHALL have ports: rdata  output  16  read data returned to the CPU (the CPU's din).
REQ-007 The block SHALL have ports: out_port  output  16  memory-mapped output register value.
REQ-008 The block SHALL have parameter: RAM_AW, default 12, RAM address width in bits (2^RAM_AW words).
REQ-009 The block SHALL use one clock, clk, with reset rst_n asynchronous and active-low.

Function
REQ-010 The block SHALL map addr 0x0000-0xFFEF to RAM indexed by addr[RAM_AW-1:0] (aliased), and 0xFFF0-0xFFFF to MMIO.
REQ-011 The block SHALL return rdata combinationally from the current addr (zero-cycle read latency); writes SHALL take effect at the clk edge where we=1.
REQ-012 A read of an address being written in the same cycle SHALL return the old value; the new value SHALL appear from the next cycle.
REQ-013 MMIO map: 0xFFF0 CTRL (bit0 RUN r/w, bit1 STEP write-only, reads 0); 0xFFF1 LFSR (write loads seed, read returns state); 0xFFF2 COUNT (read-only); 0xFFF3 OUT (r/w, drives out_port); 0xFFF4-0xFFFF read 0x0000, writes ignored.
REQ-014 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1: next = {state[14:0], state[15]^state[13]^state[12]^state[10]}.
REQ-015 The LFSR SHALL advance one step per clk while RUN=1, or exactly once in the cycle after a CTRL write with bit1=1 when RUN=0.
REQ-016 A STEP request written while RUN=1 SHALL produce no extra step; STEP SHALL be self-clearing after one cycle.
REQ-017 A seed write of 0x0000 SHALL load 0x0001 (lock-up avoidance); any other value SHALL load unchanged.
REQ-018 An LFSR write SHALL take priority over a step in the same cycle and SHALL clear COUNT to 0.
REQ-019 COUNT SHALL increment by 1 on every LFSR step and wrap 0xFFFF->0x0000.
REQ-020 Writes to COUNT SHALL be ignored.
REQ-021 RAM writes SHALL never alter MMIO state and MMIO writes SHALL never alter RAM.

Reset
REQ-022 On rst_n low: LFSR=0x0001, RUN=0, STEP pending=0, COUNT=0x0000, OUT=0x0000 (out_port=0x0000), immediately and independent of clk.
REQ-023 RAM contents SHALL NOT be cleared by reset.
REQ-024 Reset asserted mid-run SHALL stop stepping at once; after deassertion no step SHALL occur until RUN or STEP is written.

Configuration
REQ-025 With macro ALBACORE_MEMSYS_LFSR_EN defined, the LFSR, CTRL and COUNT registers SHALL be implemented as above.
REQ-026 Without ALBACORE_MEMSYS_LFSR_EN, 0xFFF0-0xFFF2 SHALL read 0x0000 and ignore writes, no LFSR logic SHALL be synthesized, and RAM and OUT SHALL behave unchanged.

Verification
REQ-027 Reset, read 0xFFF1, 0xFFF2, 0xFFF3 -> 0x0001, 0x0000, 0x0000; out_port=0x0000.
REQ-028 Write 0x1234 to 0x0010, read 0x0010 and alias 0x1010 (RAM_AW=12) -> 0x1234 both; same-cycle read during write returns old value.
REQ-029 Write LFSR 0xACE1, write CTRL=0x0002, read 0xFFF1 -> 0x59C3, COUNT -> 0x0001.
REQ-030 Write LFSR 0x0000 -> reads 0x0001; write CTRL=0x0001 for 3 cycles from 0x0001 -> 0x0002, 0x0004, 0x0008; COUNT=3; LFSR write during RUN -> seed wins, COUNT=0.
REQ-031 Write OUT 0xBEEF -> out_port=0xBEEF next cycle; assert rst_n low mid-run -> out_port=0x0000, LFSR=0x0001 asynchronously, RAM unchanged.
REQ-032 Build without ALBACORE_MEMSYS_LFSR_EN: write 0xFFF1=0x5555, read 0xFFF1 -> 0x0000; OUT and RAM tests still pass.

Source files
------------

// File: rtl/albacore_memsys.sv
// albacore_memsys -- CPU-side memory system: word RAM plus a small MMIO block.
//
// Address map (16-bit word addresses):
//   0x0000-0xFFEF  RAM, indexed by addr[RAM_AW-1:0] (upper bits alias)
//   0xFFF0         CTRL  bit0 RUN (r/w), bit1 STEP (write-only, reads 0)
//   0xFFF1         LFSR  write loads seed (0 -> 1), read returns state
//   0xFFF2         COUNT LFSR step count, read-only
//   0xFFF3         OUT   r/w, drives out_port
//   0xFFF4-0xFFFF  read 0, writes ignored
//
// Optional feature macro: ALBACORE_MEMSYS_LFSR_EN. When it is undefined, CTRL,
// LFSR and COUNT are absent and 0xFFF0-0xFFF2 read as zero.
//
// Ports:
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset (RAM is not cleared)
//   addr     in   16  word address
//   wdata    in   16  write data
//   we       in   1   write enable
//   rdata    out  16  combinational read data for addr
//   out_port out  16  OUT register value
//
// Access semantics: a write commits at the rising clk edge where we=1. rdata
// is a pure function of addr and current state, so a read of the location
// being written shows the old value until the edge.
module albacore_memsys #(
  parameter int RAM_AW = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  output logic [15:0] rdata,
  output logic [15:0] out_port
);

  localparam int DEPTH = 1 << RAM_AW;

  logic [15:0] mem [0:DEPTH-1];
  logic        is_mmio;
  logic        ram_we;
  logic [15:0] ram_rdata;

  assign is_mmio   = (addr[15:4] == 12'hFFF);
  assign ram_we    = we && !is_mmio;
  assign ram_rdata = mem[addr[RAM_AW-1:0]];

  // RAM has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[addr[RAM_AW-1:0]] <= wdata;
    end
  end

  // OUT register
  logic [15:0] out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (we && is_mmio && addr[3:0] == 4'h3) begin
      out_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= 16'h0000;
    else        out_q <= out_d;
  end

  assign out_port = out_q;

`ifdef ALBACORE_MEMSYS_LFSR_EN
  logic        run_q, run_d;
  logic        step_pending_q, step_pending_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] count_q, count_d;
  logic        ctrl_we, lfsr_we, do_step;

  assign ctrl_we = we && is_mmio && addr[3:0] == 4'h0;
  assign lfsr_we = we && is_mmio && addr[3:0] == 4'h1;
  assign do_step = run_q || step_pending_q;

  always_comb begin
    run_d          = run_q;
    step_pending_d = 1'b0;
    lfsr_d         = lfsr_q;
    count_d        = count_q;
    if (ctrl_we) begin
      run_d = wdata[0];
      // A single step is only queued when the generator is idle both before
      // and after the write; otherwise RUN already provides the stepping.
      step_pending_d = wdata[1] && !wdata[0] && !run_q;
    end
    if (lfsr_we) begin
      // Seed load wins over a step in the same cycle; zero would lock up.
      lfsr_d  = (wdata == 16'h0000) ? 16'h0001 : wdata;
      count_d = 16'h0000;
    end else if (do_step) begin
      lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      count_d = count_q + 16'h0001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q          <= 1'b0;
      step_pending_q <= 1'b0;
      lfsr_q         <= 16'h0001;
      count_q        <= 16'h0000;
    end else begin
      run_q          <= run_d;
      step_pending_q <= step_pending_d;
      lfsr_q         <= lfsr_d;
      count_q        <= count_d;
    end
  end
`endif

  always_comb begin
    rdata = ram_rdata;
    if (is_mmio) begin
      rdata = 16'h0000;
      case (addr[3:0])
`ifdef ALBACORE_MEMSYS_LFSR_EN
        4'h0:    rdata = {15'h0000, run_q};
        4'h1:    rdata = lfsr_q;
        4'h2:    rdata = count_q;
`endif
        4'h3:    rdata = out_q;
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule
